// File: rtl/reg_file_pkg.sv
// Shared core definitions for the integer register file: architectural
// sizes, the hardwired-zero register index and common data/address types.
package reg_file_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/reg_file.sv
// RISC-V integer register file: x1..x31 hold state, x0 always reads zero.
// Two combinational read ports and one write port that updates on the rising
// clock edge. Reads see the old value until the writing edge (no bypass).
module reg_file #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regfile_wren,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  input  logic [ADDR_W-1:0] write_addr3,
  input  logic [XLEN-1:0]   regfile_data_in3,
  output logic [XLEN-1:0]   regfile_data_out1,
  output logic [XLEN-1:0]   regfile_data_out2
);

  import reg_file_pkg::*;

  // x0 has no storage; the array starts at index 1.
  logic [XLEN-1:0] regs_q [NREGS-1:1];
  logic            wr_en_d;

  assign wr_en_d = regfile_wren && (write_addr3 != REG_ZERO);

  // Storage: cleared asynchronously on reset, written on the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_d) begin
      regs_q[write_addr3] <= regfile_data_in3;
    end
  end

  // Read port 1: combinational mux with x0 forced to zero.
  always_comb begin
    regfile_data_out1 = '0;
    if (read_addr1 != REG_ZERO) begin
      regfile_data_out1 = regs_q[read_addr1];
    end
  end

  // Read port 2: combinational mux with x0 forced to zero.
  always_comb begin
    regfile_data_out2 = '0;
    if (read_addr2 != REG_ZERO) begin
      regfile_data_out2 = regs_q[read_addr2];
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: the driver applies stimulus, predicts both
// read ports from an array model and queues the prediction; a monitor pops
// each prediction shortly after it is posted and compares the DUT outputs.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        regfile_wren;
  logic [4:0]  read_addr1;
  logic [4:0]  read_addr2;
  logic [4:0]  write_addr3;
  logic [31:0] regfile_data_in3;
  logic [31:0] regfile_data_out1;
  logic [31:0] regfile_data_out2;

  reg_file #(.XLEN(32), .NREGS(32), .ADDR_W(5)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .regfile_wren      (regfile_wren),
    .read_addr1        (read_addr1),
    .read_addr2        (read_addr2),
    .write_addr3       (write_addr3),
    .regfile_data_in3  (regfile_data_in3),
    .regfile_data_out1 (regfile_data_out1),
    .regfile_data_out2 (regfile_data_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] e1;
    logic [31:0] e2;
  } sb_t;

  sb_t         sbq[$];
  event        sample_ev;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] model [32];

  function automatic logic [31:0] ref_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : model[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  // Queue a prediction for the current read addresses and hand it to the monitor.
  task automatic check(input string nm);
    sb_t s;
    s.nm = nm;
    s.e1 = ref_rd(read_addr1);
    s.e2 = ref_rd(read_addr2);
    sbq.push_back(s);
    ->sample_ev;
    #2;
  endtask

  // One rising edge; the model commits the write the DUT should commit.
  task automatic tick();
    @(posedge clk);
    if (regfile_wren && rst_n && write_addr3 != 5'd0)
      model[write_addr3] = regfile_data_in3;
    #1;
  endtask

  // Monitor: compare each queued prediction against the live outputs.
  initial begin
    sb_t e;
    forever begin
      @(sample_ev);
      #1;
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: no prediction queued");
      end else begin
        e = sbq.pop_front();
        total++;
        if (regfile_data_out1 !== e.e1) begin
          bad++;
          $display("FAIL %s out1: got %h expected %h", e.nm, regfile_data_out1, e.e1);
        end
        total++;
        if (regfile_data_out2 !== e.e2) begin
          bad++;
          $display("FAIL %s out2: got %h expected %h", e.nm, regfile_data_out2, e.e2);
        end
      end
    end
  end

  // Driver.
  initial begin
    rst_n            = 1'b0;
    regfile_wren     = 1'b0;
    read_addr1       = 5'd0;
    read_addr2       = 5'd31;
    write_addr3      = 5'd0;
    regfile_data_in3 = 32'd0;
    model_clear();
    #1;
    check("reset_state");
    read_addr1 = 5'd17;
    read_addr2 = 5'd1;
    check("reset_state2");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fill every address with i+100 (x0 write discarded).
    for (int i = 0; i < 32; i++) begin
      regfile_wren     = 1'b1;
      write_addr3      = 5'(i);
      regfile_data_in3 = 32'(i + 100);
      tick();
    end
    regfile_wren = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read_addr1 = 5'(i);
      read_addr2 = 5'(31 - i);
      check("fill_read");
    end
    read_addr1 = 5'd31;
    read_addr2 = 5'd0;
    if (ref_rd(5'd31) != 32'd131) $display("note: model x31 unexpected");
    check("x31_port1");

    // Disabled write must not change anything.
    regfile_wren     = 1'b0;
    write_addr3      = 5'd5;
    regfile_data_in3 = 32'hDEADBEEF;
    tick();
    read_addr1 = 5'd5;
    read_addr2 = 5'd5;
    check("wren_low");

    // Adjacent pairs on both ports.
    for (int j = 1; j <= 29; j += 2) begin
      read_addr1 = 5'(j);
      read_addr2 = 5'(j + 1);
      check("pair_read");
    end

    // Read-during-write: old value before the edge, new value right after.
    read_addr1       = 5'd7;
    read_addr2       = 5'd7;
    regfile_wren     = 1'b1;
    write_addr3      = 5'd7;
    regfile_data_in3 = 32'h12345678;
    check("rdw_before");
    tick();
    regfile_wren = 1'b0;
    check("rdw_after");

    // Writes to x0 are discarded.
    regfile_wren     = 1'b1;
    write_addr3      = 5'd0;
    regfile_data_in3 = 32'hFFFFFFFF;
    tick();
    regfile_wren = 1'b0;
    read_addr1   = 5'd0;
    read_addr2   = 5'd0;
    check("x0_write");

    // Randomized traffic, checked before each edge.
    for (int n = 0; n < 300; n++) begin
      regfile_wren     = 1'($urandom_range(0, 1));
      write_addr3      = 5'($urandom_range(0, 31));
      regfile_data_in3 = $urandom;
      read_addr1       = ($urandom_range(0, 3) == 0) ? write_addr3 : 5'($urandom_range(0, 31));
      read_addr2       = 5'($urandom_range(0, 31));
      check("random");
      tick();
    end
    regfile_wren = 1'b0;

    // Mid-cycle reset with a pending write: contents clear at once, write lost.
    regfile_wren     = 1'b1;
    write_addr3      = 5'd31;
    regfile_data_in3 = 32'hA5A5A5A5;
    read_addr1       = 5'd31;
    read_addr2       = 5'd3;
    rst_n            = 1'b0;
    model_clear();
    check("async_reset");
    tick();
    check("reset_write_blocked");
    regfile_wren = 1'b0;
    rst_n        = 1'b1;
    for (int i = 0; i < 32; i++) begin
      read_addr1 = 5'(i);
      read_addr2 = 5'(31 - i);
      check("post_reset");
    end

    // First write after release lands on the first edge.
    regfile_wren     = 1'b1;
    write_addr3      = 5'd9;
    regfile_data_in3 = 32'hCAFEF00D;
    read_addr1       = 5'd9;
    read_addr2       = 5'd31;
    tick();
    regfile_wren = 1'b0;
    check("first_write");

    // Drain: anything left unchecked is a failure.
    for (int k = 0; k < 20 && sbq.size() != 0; k++) #1;
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_drain: %0d left, expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
